// File: rtl/pipelined_cla_adder_pkg.sv
// Shared ALU operation encodings and the operand/carry conditioning used by
// the pipelined lookahead adder and the ALU decode.
package pipelined_cla_adder_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Subtract forms add the one's complement of b.
  function automatic logic op_invert_b(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_ADC:  c = cin;
      OP_SUB:  c = 1'b1;
      OP_SBB:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bus for the pipelined lookahead adder.
interface pipelined_cla_adder_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipelined_cla_adder_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder: every carry is a flat
// sum-of-products of generate/propagate terms and the slice carry-in.
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic             term;
  logic             prop;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one SLICE-bit lookahead slice per stage with the
// carry registered between stages; a single global advance gates every stage.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_adder_if.slave  bus
);

  localparam int NSTAGE = WIDTH / SLICE;
  localparam int LAST   = NSTAGE - 1;

  generate
    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic             vld_q   [NSTAGE];
  logic             vld_d   [NSTAGE];
  logic [WIDTH-1:0] a_q     [NSTAGE];
  logic [WIDTH-1:0] a_d     [NSTAGE];
  logic [WIDTH-1:0] b_q     [NSTAGE];
  logic [WIDTH-1:0] b_d     [NSTAGE];
  logic [WIDTH-1:0] sum_q   [NSTAGE];
  logic [WIDTH-1:0] sum_d   [NSTAGE];
  logic             carry_q [NSTAGE];
  logic             carry_d [NSTAGE];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] sl_a    [NSTAGE];
  logic [SLICE-1:0] sl_b    [NSTAGE];
  logic [SLICE-1:0] sl_sum  [NSTAGE];
  logic             sl_cin  [NSTAGE];
  logic             sl_cout [NSTAGE];

  assign advance      = !vld_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  assign b_in = op_invert_b(bus.op) ? ~bus.b : bus.b;
  assign c_in = op_carry_in(bus.op, bus.cin);

  // Stage 0 adds straight from the bus; later stages take the skewed operands.
  always_comb begin : slice_inputs
    sl_a[0]   = bus.a[SLICE-1:0];
    sl_b[0]   = b_in[SLICE-1:0];
    sl_cin[0] = c_in;
    for (int k = 1; k < NSTAGE; k++) begin
      sl_a[k]   = a_q[k-1][k*SLICE +: SLICE];
      sl_b[k]   = b_q[k-1][k*SLICE +: SLICE];
      sl_cin[k] = carry_q[k-1];
    end
  end

  generate
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      cla_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a[k]),
        .b    (sl_b[k]),
        .cin  (sl_cin[k]),
        .sum  (sl_sum[k]),
        .cout (sl_cout[k])
      );
    end
  endgenerate

  always_comb begin : stage_next
    vld_d[0]   = bus.in_valid;
    a_d[0]     = bus.a;
    b_d[0]     = b_in;
    sum_d[0]   = '0;
    sum_d[0][SLICE-1:0] = sl_sum[0];
    carry_d[0] = sl_cout[0];
    for (int k = 1; k < NSTAGE; k++) begin
      vld_d[k]   = vld_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      sum_d[k]   = sum_q[k-1];
      sum_d[k][k*SLICE +: SLICE] = sl_sum[k];
      carry_d[k] = sl_cout[k];
    end
    // Flags are formed as the last slice completes so they register with sum.
    ovf_d  = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
             (sum_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    zero_d = (sum_d[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        vld_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSTAGE; k++) begin
        vld_q[k]   <= vld_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
